// File: rtl/fpu_issue_arbiter.sv
// Shared-FPU issue arbiter: round-robin selection of one lane request per cycle,
// result tagged with the requester index and collected into a response FIFO.

package OpCodes;
  localparam int OPW = 2;
  typedef enum logic [OPW-1:0] {
    FMAD = 2'd0,
    FMUL = 2'd1,
    FADD = 2'd2,
    FSUB = 2'd3
  } opcode_e;
endpackage

module fpu_issue_arbiter #(
  parameter int NREQ   = 4,
  parameter int NSIG   = 32,
  parameter int W      = NSIG + 1,
  parameter int RDEPTH = 2,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][W-1:0]              req_a,
  input  logic [NREQ-1:0][W-1:0]              req_b,
  input  logic [NREQ-1:0][W-1:0]              req_c,
  input  logic [NREQ-1:0][OpCodes::OPW-1:0]   req_op,
  output logic [W-1:0]                        fpu_a,
  output logic [W-1:0]                        fpu_b,
  output logic [W-1:0]                        fpu_c,
  output logic [OpCodes::OPW-1:0]             fpu_op,
  input  logic [W-1:0]                        fpu_out,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [W-1:0]                        resp_data,
  output logic [IDW-1:0]                      resp_id
);

  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = $clog2(RDEPTH + 1);
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(RDEPTH);

  logic [IDW-1:0] r_ptr;
  logic           r_infl;
  logic [IDW-1:0] r_inflId;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_wrPtr;
  logic [PW-1:0]  r_rdPtr;
  logic [W-1:0]   r_memData [RDEPTH];
  logic [IDW-1:0] r_memId   [RDEPTH];

  logic           w_pop;
  logic [CW:0]    w_occ;
  logic           w_en;
  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic           w_xfer;

  // Requester index base+off, wrapped into 0..NREQ-1.
  function automatic logic [IDW-1:0] wrapIdx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // FIFO pointer increment with wrap at RDEPTH (depth need not be a power of two).
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(RDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Response side is forced quiet while reset is held so no stale head leaks out.
  assign resp_valid = rst_n & (r_cnt != '0);
  assign resp_data  = r_memData[r_rdPtr];
  assign resp_id    = r_memId[r_rdPtr];
  assign w_pop      = resp_valid & resp_ready;

  // Slots already promised (stored + in flight) minus the one leaving this cycle.
  assign w_occ  = {1'b0, r_cnt} + {{CW{1'b0}}, r_infl} - {{CW{1'b0}}, w_pop};
  assign w_en   = (w_occ < L_DEPTH);
  assign w_xfer = rst_n & w_en & w_found;

  // Round-robin search: first valid requester at or after r_ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrapIdx(int'(r_ptr), k)]) begin
        w_found = 1'b1;
        w_grant = wrapIdx(int'(r_ptr), k);
      end
    end
  end

  // Grant and FPU operand steering; idle cycles present zeros and FMAD.
  always_comb begin
    req_ready = '0;
    fpu_a     = '0;
    fpu_b     = '0;
    fpu_c     = '0;
    fpu_op    = OpCodes::FMAD;
    if (w_xfer) begin
      req_ready = NREQ'(1) << w_grant;
      fpu_a     = req_a[w_grant];
      fpu_b     = req_b[w_grant];
      fpu_c     = req_c[w_grant];
      fpu_op    = req_op[w_grant];
    end
  end

  // Arbiter state: in-flight marker, its requester tag, and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_infl   <= 1'b0;
      r_inflId <= '0;
    end else begin
      r_infl <= w_xfer;
      if (w_xfer) begin
        r_inflId <= w_grant;
        r_ptr    <= wrapIdx(int'(w_grant), 1);
      end
    end
  end

  // FIFO bookkeeping: the result on fpu_out is pushed whenever an issue is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_infl) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      if (r_infl && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!r_infl && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // FIFO storage; contents need no reset because r_cnt gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && r_infl) begin
      r_memData[r_wrPtr] <= fpu_out;
      r_memId[r_wrPtr]   <= r_inflId;
    end
  end

  // The issue-enable rule must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(r_infl && !w_pop && (r_cnt == CW'(RDEPTH))));

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter with a behavioural one-cycle FPU
// and a scoreboard of expected {result, id} pairs in issue order.

module tb_fpu_issue_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 33;
  localparam int IDW  = 2;
  localparam int OPW  = OpCodes::OPW;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ-1:0][W-1:0]        req_a, req_b, req_c;
  logic [NREQ-1:0][OPW-1:0]      req_op;
  logic [W-1:0]                  fpu_a, fpu_b, fpu_c;
  logic [OPW-1:0]                fpu_op;
  logic [W-1:0]                  fpuOut = '0;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [W-1:0]                  resp_data;
  logic [IDW-1:0]                resp_id;

  int vecCount  = 0;
  int missCount = 0;
  int pending [NREQ];
  int seqNum  [NREQ];
  logic [NREQ-1:0]     xferMask = '0;
  logic [W+IDW-1:0]    expQ[$];
  int                  grantQ[$];

  fpu_issue_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .req_op     (req_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_c      (fpu_c),
    .fpu_op     (fpu_op),
    .fpu_out    (fpuOut),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Integer stand-in for the FPU arithmetic, truncated to the datapath width.
  function automatic logic [W-1:0] fpuRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [OPW-1:0] op);
    case (op)
      2'd0:    return a * b + c;
      2'd1:    return a * b;
      2'd2:    return a + b;
      default: return a - b;
    endcase
  endfunction

  // Behavioural FPU: registers its result so it appears one cycle after issue.
  always @(posedge clk) fpuOut <= fpuRef(fpu_a, fpu_b, fpu_c, fpu_op);

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Present the current operation of requester i, or drop its valid when it has none left.
  task automatic loadReq(input int i);
    if (pending[i] > 0) begin
      req_valid[i] = 1'b1;
      req_a[i]     = W'(i + 1 + 7 * seqNum[i]);
      req_b[i]     = W'(4 + 3 * seqNum[i]);
      req_c[i]     = W'(i + 3 + seqNum[i]);
      req_op[i]    = OPW'(seqNum[i] % 4);
    end else begin
      req_valid[i] = 1'b0;
      req_a[i]     = '0;
      req_b[i]     = '0;
      req_c[i]     = '0;
      req_op[i]    = '0;
    end
  endtask

  // Give requester i a burst of n operations.
  task automatic applyStimulus(input int i, input int n);
    pending[i] = n;
    loadReq(i);
  endtask

  // Advance one clock; accepted requesters move on to their next operation.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xferMask[i] && pending[i] > 0) begin
        pending[i]--;
        seqNum[i]++;
        loadReq(i);
      end
    end
  endtask

  // Two-cycle reset that abandons all outstanding requests.
  task automatic resetDut();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("rst resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst req_ready", 64'(req_ready), 64'd0);
    stepCycle();
    rst_n = 1'b1;
    grantQ.delete();
  endtask

  // Monitor away from the active edge: logs grants, checks FPU steering, runs the scoreboard.
  always @(negedge clk) begin
    logic [W+IDW-1:0] head;
    xferMask = req_valid & req_ready;
    checkOutput("ready one-hot", 64'($countones(req_ready) <= 1), 64'd1);
    if (xferMask == '0) begin
      checkOutput("idle fpu_a", 64'(fpu_a), 64'd0);
      checkOutput("idle fpu_b", 64'(fpu_b), 64'd0);
      checkOutput("idle fpu_c", 64'(fpu_c), 64'd0);
      checkOutput("idle fpu_op", 64'(fpu_op), 64'(OpCodes::FMAD));
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xferMask[i]) begin
          checkOutput("route fpu_a", 64'(fpu_a), 64'(req_a[i]));
          checkOutput("route fpu_op", 64'(fpu_op), 64'(req_op[i]));
          expQ.push_back({fpuRef(req_a[i], req_b[i], req_c[i], req_op[i]), IDW'(i)});
          grantQ.push_back(i);
        end
      end
    end
    if (!rst_n) begin
      expQ.delete();
    end else if (resp_valid && resp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious resp", 64'(resp_valid), 64'd0);
      end else begin
        head = expQ.pop_front();
        checkOutput("resp_data", 64'(resp_data), 64'(head[W+IDW-1:IDW]));
        checkOutput("resp_id", 64'(resp_id), 64'(head[IDW-1:0]));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, missCount=%0d", missCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int n;
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    req_valid  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 0;
      seqNum[i]  = 0;
      loadReq(i);
    end
    repeat (2) stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // Single op from requester 2: 3*4+5 = 17, response two cycles later.
    resp_ready = 1'b1;
    applyStimulus(2, 1);
    @(negedge clk);
    checkOutput("t0 req_ready", 64'(req_ready), 64'h4);
    checkOutput("t0 fpu_a", 64'(fpu_a), 64'd3);
    stepCycle();
    @(negedge clk);
    checkOutput("t1 resp_valid", 64'(resp_valid), 64'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("t2 resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("t2 resp_data", 64'(resp_data), 64'd17);
    checkOutput("t2 resp_id", 64'(resp_id), 64'd2);
    stepCycle();

    // All four requesters busy: 0,1,2,3 repeating, one issue per cycle.
    resetDut();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 3);
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (grantQ.size() < 12 && n < 40);
    checkOutput("rr cycles for 12", 64'(n), 64'd12);
    for (int k = 0; k < 12; k++) checkOutput("rr order", 64'(grantQ[k]), 64'(k % 4));
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("rr drained", 64'(expQ.size()), 64'd0);

    // Backpressure: only RDEPTH issues while the consumer stalls.
    resetDut();
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1);
    repeat (5) stepCycle();
    checkOutput("bp issued", 64'(grantQ.size()), 64'd2);
    checkOutput("bp grant0", 64'(grantQ[0]), 64'd0);
    checkOutput("bp grant1", 64'(grantQ[1]), 64'd1);
    @(negedge clk);
    checkOutput("bp stalled ready", 64'(req_ready), 64'd0);
    checkOutput("bp head valid", 64'(resp_valid), 64'd1);
    checkOutput("bp head id", 64'(resp_id), 64'd0);
    checkOutput("bp head data", 64'(resp_data), 64'(expQ[0][W+IDW-1:IDW]));
    stepCycle();
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp resume ready", 64'(req_ready), 64'h4);
    n = 0;
    while ((expQ.size() > 0 || pending[2] > 0 || pending[3] > 0) && n < 30) begin
      stepCycle();
      n++;
    end
    checkOutput("bp total grants", 64'(grantQ.size()), 64'd4);
    for (int k = 0; k < 4; k++) checkOutput("bp grant order", 64'(grantQ[k]), 64'(k));
    checkOutput("bp drained", 64'(expQ.size()), 64'd0);

    // Fairness from ptr=3 with only requesters 1 and 3 asking.
    resetDut();
    applyStimulus(2, 1);
    repeat (4) stepCycle();
    grantQ.delete();
    applyStimulus(1, 2);
    applyStimulus(3, 2);
    repeat (8) stepCycle();
    checkOutput("fair count", 64'(grantQ.size()), 64'd4);
    checkOutput("fair g0", 64'(grantQ[0]), 64'd3);
    checkOutput("fair g1", 64'(grantQ[1]), 64'd1);
    checkOutput("fair g2", 64'(grantQ[2]), 64'd3);
    checkOutput("fair g3", 64'(grantQ[3]), 64'd1);

    // Reset right after an issue discards the in-flight result and rewinds the pointer.
    resetDut();
    applyStimulus(0, 1);
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("post-rst resp_valid", 64'(resp_valid), 64'd0);
      stepCycle();
    end
    grantQ.delete();
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    repeat (5) stepCycle();
    checkOutput("post-rst grants", 64'(grantQ.size()), 64'd2);
    checkOutput("post-rst first", 64'(grantQ[0]), 64'd0);
    checkOutput("post-rst second", 64'(grantQ[1]), 64'd1);

    // Idle: nothing requested, FPU inputs parked, no responses.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("idle resp_valid", 64'(resp_valid), 64'd0);
      stepCycle();
    end
    checkOutput("final scoreboard", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
